// File: rtl/clk_div_cfg_arbiter.sv
`timescale 1ns/1ps
// Shares the odd/even divider ratio inputs between NREQ requesters with round-robin grant.
// A request is checked, then held until a divider period boundary or a timeout, then applied.
// Applying a ratio also pulses div_rst so both counters restart cleanly. All outputs are registered.
module clk_div_cfg_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 12,
  parameter int DEF_ODD  = 3,
  parameter int DEF_EVEN = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_sel,
  input  logic [NREQ*W-1:0]   req_div,
  input  logic                period_end,
  output logic [W-1:0]        div_odd,
  output logic [W-1:0]        div_even,
  output logic                div_rst,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     nack,
  output logic                forced,
  output logic                busy
);

  // Pointer width covers NREQ=2..8; counter width covers 0..TIMEOUT-1.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] CNT_TOP   = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);
  localparam logic [W-1:0]  RST_ODD   = W'(DEF_ODD);
  localparam logic [W-1:0]  RST_EVEN  = W'(DEF_EVEN);
  localparam logic [W-1:0]  MIN_ODD   = W'(3);
  localparam logic [W-1:0]  MIN_EVEN  = W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_BND,
    S_APPLY,
    S_RESP,
    S_COOL
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt;
  logic            hold_sel;
  logic [W-1:0]    hold_div;
  logic [CW-1:0]   cnt;
  logic            flag;

  // Combinational helpers
  logic            found;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   ptr_nxt;
  logic [W-1:0]    sel_div;
  logic [W-1:0]    cur_val;
  logic            div_valid;
  int              cand;

  // Round-robin search: first asserted request at or after the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
  end

  // Next pointer value and the ratio offered by the winning requester.
  always_comb begin
    ptr_nxt = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + PW'(1);
    sel_div = req_div[int'(gnt_idx)*W +: W];
  end

  // Ratio check on the captured request: odd target needs an odd value >= 3,
  // even target needs an even value >= 2.
  always_comb begin
    cur_val   = hold_sel ? div_even : div_odd;
    div_valid = hold_sel ? (!hold_div[0] && (hold_div >= MIN_EVEN))
                         : ( hold_div[0] && (hold_div >= MIN_ODD));
  end

  // Arbiter FSM with all outputs registered; response strobes default low each cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gnt      <= '0;
      hold_sel <= 1'b0;
      hold_div <= '0;
      cnt      <= '0;
      flag     <= 1'b0;
      div_odd  <= RST_ODD;
      div_even <= RST_EVEN;
      div_rst  <= 1'b1;
      ack      <= '0;
      nack     <= '0;
      forced   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      div_rst <= 1'b0;
      ack     <= '0;
      nack    <= '0;
      forced  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt      <= gnt_idx;
            hold_sel <= req_sel[gnt_idx];
            hold_div <= sel_div;
            ptr      <= ptr_nxt;
            busy     <= 1'b1;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!div_valid) begin
            nack[gnt] <= 1'b1;
            state     <= S_RESP;
          end else if (hold_div == cur_val) begin
            // Already in effect: acknowledge without touching the divider.
            ack[gnt] <= 1'b1;
            state    <= S_RESP;
          end else begin
            cnt   <= '0;
            flag  <= 1'b0;
            state <= S_WAIT_BND;
          end
        end
        S_WAIT_BND: begin
          // A boundary wins over a simultaneous timeout, so forced stays clear then.
          if (period_end) begin
            state <= S_APPLY;
          end else if (cnt == CNT_TOP) begin
            flag  <= 1'b1;
            state <= S_APPLY;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_APPLY: begin
          // New ratio and divider reset appear together, alongside the response.
          if (hold_sel) begin
            div_even <= hold_div;
          end else begin
            div_odd <= hold_div;
          end
          div_rst  <= 1'b1;
          ack[gnt] <= 1'b1;
          forced   <= flag;
          flag     <= 1'b0;
          state    <= S_RESP;
        end
        S_RESP: begin
          state <= S_COOL;
        end
        S_COOL: begin
          // Gives the served requester a cycle to drop req before re-arbitration.
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_arbiter.sv
`timescale 1ns/1ps
// Directed bench for clk_div_cfg_arbiter with TIMEOUT=16.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Monitors on the falling edge count div_rst cycles and response strobes.
module tb_clk_div_cfg_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int TMO  = 16;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_sel;
  logic [NREQ*W-1:0] req_div;
  logic              period_end;
  logic [W-1:0]      div_odd;
  logic [W-1:0]      div_even;
  logic              div_rst;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   nack;
  logic              forced;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int rst_pulses = 0;
  int resp_events = 0;

  clk_div_cfg_arbiter #(
    .NREQ(NREQ), .W(W), .DEF_ODD(3), .DEF_EVEN(2), .TIMEOUT(TMO)
  ) dut (
    .clk_in(clk_in), .rst(rst), .req(req), .req_sel(req_sel), .req_div(req_div),
    .period_end(period_end), .div_odd(div_odd), .div_even(div_even), .div_rst(div_rst),
    .ack(ack), .nack(nack), .forced(forced), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Count divider-reset cycles outside of rst and every response strobe cycle.
  always @(negedge clk_in) begin
    if (!rst && div_rst) rst_pulses <= rst_pulses + 1;
    if ((|ack) || (|nack)) resp_events <= resp_events + 1;
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request, optionally pulse period_end in cycle pe_cyc (cycle 0 = CHECK),
  // wait for ack/nack, then drop req and return to IDLE.
  task automatic run_req(input int idx, input logic sel, input logic [W-1:0] dv,
                         input int pe_cyc, input int maxc,
                         output int lat, output logic [NREQ-1:0] a,
                         output logic [NREQ-1:0] na, output logic f,
                         output logic dr, output int pulses);
    int p0;
    p0 = rst_pulses;
    lat = -1; a = '0; na = '0; f = 1'b0; dr = 1'b0;
    req_sel[idx] = sel;
    req_div[idx*W +: W] = dv;
    req[idx] = 1'b1;
    tick();
    for (int n = 0; n < maxc; n++) begin
      if ((|ack) || (|nack)) begin
        lat = n + 1; a = ack; na = nack; f = forced; dr = div_rst;
        break;
      end
      period_end = (n == pe_cyc);
      tick();
    end
    req[idx] = 1'b0;
    period_end = 1'b0;
    tick();
    tick();
    pulses = rst_pulses - p0;
  endtask

  initial begin
    int lat;
    int pulses;
    int ev0;
    logic [NREQ-1:0] a;
    logic [NREQ-1:0] na;
    logic [NREQ-1:0] got;
    logic f;
    logic dr;

    rst = 1'b1; req = '0; req_sel = '0; req_div = '0; period_end = 1'b0;

    // Reset held three cycles
    tick(); tick(); tick();
    chk("rst_odd", 32'(div_odd), 3);
    chk("rst_even", 32'(div_even), 2);
    chk("rst_divrst", 32'(div_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp", {28'd0, ack | nack}, 0);
    rst = 1'b0;
    tick();
    chk("rst_release_divrst", 32'(div_rst), 0);

    // Single valid change on requester 1, boundary two cycles into the wait
    run_req(1, 1'b0, 12'd5, 3, 40, lat, a, na, f, dr, pulses);
    chk("single_lat", lat, 6);
    chk("single_ack", 32'(a), 32'b0010);
    chk("single_nack", 32'(na), 0);
    chk("single_forced", 32'(f), 0);
    chk("single_divrst_with_ack", 32'(dr), 1);
    chk("single_pulses", pulses, 1);
    chk("single_odd", 32'(div_odd), 5);
    chk("single_even", 32'(div_even), 2);
    chk("single_busy_after", 32'(busy), 0);

    // Invalid ratios: each is rejected with nothing changed
    run_req(2, 1'b0, 12'd4, -1, 40, lat, a, na, f, dr, pulses);
    chk("inv_odd4_lat", lat, 2);
    chk("inv_odd4_nack", 32'(na), 32'b0100);
    chk("inv_odd4_ack", 32'(a), 0);
    chk("inv_odd4_pulses", pulses, 0);
    run_req(3, 1'b1, 12'd0, -1, 40, lat, a, na, f, dr, pulses);
    chk("inv_even0_nack", 32'(na), 32'b1000);
    chk("inv_even0_pulses", pulses, 0);
    run_req(0, 1'b0, 12'd1, -1, 40, lat, a, na, f, dr, pulses);
    chk("inv_odd1_nack", 32'(na), 32'b0001);
    chk("inv_odd1_pulses", pulses, 0);
    chk("inv_odd_kept", 32'(div_odd), 5);
    chk("inv_even_kept", 32'(div_even), 2);

    // Timeout: no boundary, apply after 16 wait cycles with forced
    run_req(1, 1'b1, 12'd6, -1, 40, lat, a, na, f, dr, pulses);
    chk("tmo_lat", lat, TMO + 3);
    chk("tmo_ack", 32'(a), 32'b0010);
    chk("tmo_forced", 32'(f), 1);
    chk("tmo_pulses", pulses, 1);
    chk("tmo_even", 32'(div_even), 6);
    chk("tmo_odd_kept", 32'(div_odd), 5);

    // No-op requests: already in effect, quick ack without divider reset
    run_req(2, 1'b1, 12'd6, -1, 40, lat, a, na, f, dr, pulses);
    chk("noop_even_lat", lat, 2);
    chk("noop_even_ack", 32'(a), 32'b0100);
    chk("noop_even_forced", 32'(f), 0);
    chk("noop_even_pulses", pulses, 0);
    run_req(3, 1'b0, 12'd5, -1, 40, lat, a, na, f, dr, pulses);
    chk("noop_odd_ack", 32'(a), 32'b1000);
    chk("noop_odd_pulses", pulses, 0);

    // Round robin with all four requesting; pointer is back at 0 here
    req_sel = 4'b1010;
    req_div = {12'd8, 12'd7, 12'd8, 12'd7};
    period_end = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      got = '0;
      for (int c = 0; c < 30 && got == '0; c++) begin
        tick();
        got = ack | nack;
      end
      chk($sformatf("rr_grant%0d", k), 32'(got), 32'(1) << k);
      chk($sformatf("rr_ack%0d", k), 32'(ack), 32'(1) << k);
      req = req & ~got;
    end
    tick(); tick();
    chk("rr_odd", 32'(div_odd), 7);
    chk("rr_even", 32'(div_even), 8);

    // Requesters 0 and 3 together with pointer at 0: requester 0 first
    req_sel = 4'b0000;
    req_div = {12'd7, 12'd0, 12'd0, 12'd9};
    req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      got = '0;
      for (int c = 0; c < 30 && got == '0; c++) begin
        tick();
        got = ack | nack;
      end
      chk($sformatf("rr2_grant%0d", k), 32'(got), (k == 0) ? 32'b0001 : 32'b1000);
      req = req & ~got;
    end
    period_end = 1'b0;
    tick(); tick();
    chk("rr2_odd", 32'(div_odd), 7);

    // Reset while waiting for a boundary abandons the request silently
    ev0 = resp_events;
    req_sel[1] = 1'b0;
    req_div[1*W +: W] = 12'd11;
    req[1] = 1'b1;
    tick(); tick(); tick(); tick();
    chk("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    tick(); tick();
    req = '0;
    chk("midrst_odd", 32'(div_odd), 3);
    chk("midrst_even", 32'(div_even), 2);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_divrst", 32'(div_rst), 1);
    rst = 1'b0;
    tick();
    chk("midrst_no_resp", resp_events - ev0, 0);
    chk("midrst_release_divrst", 32'(div_rst), 0);

    // Fresh request after reset, boundary in the first wait cycle
    run_req(2, 1'b1, 12'd4, 1, 40, lat, a, na, f, dr, pulses);
    chk("post_lat", lat, 4);
    chk("post_ack", 32'(a), 32'b0100);
    chk("post_forced", 32'(f), 0);
    chk("post_even", 32'(div_even), 4);
    chk("post_odd", 32'(div_odd), 3);
    chk("post_pulses", pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_cfg_arbiter.md
Name: clk_div_cfg_arbiter

Overview:
- Shares the dual odd/even clock divider between NREQ requesters that each want to reprogram one of its two divide ratios.
- Round-robin arbitrates between requests and validates the requested ratio.
- Waits for a divider period boundary, or a timeout, before updating the divider's ratio inputs. On update it pulses the divider reset so both counters restart cleanly.
- Sits between the PWM/control logic and the clock divider instance, in the clk_in domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 12, divide-ratio width; matches the divider's ratio ports.
- DEF_ODD, 3, odd ratio loaded at reset.
- DEF_EVEN, 2, even ratio loaded at reset.
- TIMEOUT, 4096, maximum cycles spent waiting for period_end before a forced apply (>=2).

Ports:
- clk_in, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- req, input, NREQ, per-requester request; held until that requester's ack/nack.
- req_sel, input, NREQ, per-requester target select: 0 = odd ratio, 1 = even ratio.
- req_div, input, NREQ*W, flattened requested ratios; requester i uses bits [i*W +: W]; stable while req[i]=1.
- period_end, input, 1, one-cycle strobe from the divider side marking an output-period boundary.
- div_odd, output, W, registered odd ratio driving the divider.
- div_even, output, W, registered even ratio driving the divider.
- div_rst, output, 1, registered reset to the divider.
- ack, output, NREQ, one-cycle pulse: request applied or already in effect.
- nack, output, NREQ, one-cycle pulse: request rejected.
- forced, output, 1, one-cycle pulse coincident with ack when the apply was caused by timeout.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; div_odd=DEF_ODD; div_even=DEF_EVEN; div_rst=1.
  - ack=0, nack=0, forced=0; round-robin pointer=0; timeout counter=0.
  - div_rst drops to 0 on the first edge with rst=0.
  - Reset mid-operation abandons the pending request; no ack/nack is ever issued for it.
- FSM states: IDLE, CHECK, WAIT_BND, APPLY, RESP, COOL.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer, wrapping modulo NREQ.
  - Capture grant index, req_sel and req_div into holding registers; go to CHECK.
  - Set pointer = grant+1 (mod NREQ).
- CHECK, one cycle:
  - Odd target is valid if value[0]=1 and value>=3.
  - Even target is valid if value[0]=0 and value>=2.
  - Invalid -> RESP with nack.
  - Valid and equal to the current output for that target -> RESP with ack; no div_rst, no update.
  - Valid and different -> WAIT_BND; timeout counter cleared.
- WAIT_BND:
  - period_end=1 -> APPLY.
  - Otherwise increment the counter; if counter==TIMEOUT-1 -> APPLY and set the forced flag.
  - period_end on the same cycle as the timeout hit counts as a boundary; forced=0.
- APPLY, one cycle: the selected output takes the captured value on the edge entering APPLY+1; div_rst=1 for exactly that one cycle, concurrent with the new value; go to RESP.
- RESP, one cycle:
  - ack[grant] or nack[grant]=1; forced=flag (ack only); flag cleared.
  - Go to COOL. Ack/nack and forced are registered outputs.
- COOL, one cycle, no arbitration; go to IDLE. Requesters must deassert req no later than the COOL cycle, otherwise the next IDLE treats it as a new request.
- Requests arriving while busy are held by the requester and are not lost; req changes outside IDLE have no effect.
- The non-selected ratio is never modified by a request.
- Latency, req seen in IDLE to ack:
  - Valid-change request with period_end present in the first WAIT_BND cycle: 4 cycles (CHECK, WAIT_BND, APPLY, RESP).
  - No-op or invalid request: 2 cycles.
  - Bounded by TIMEOUT+3.
- Width rules:
  - Comparisons are unsigned, W-bit.
  - Timeout counter width is clog2(TIMEOUT); it saturates only via the state exit.
  - All outputs are driven from flops.

Test Plan:
- Reset: rst held 3 cycles -> div_odd=3, div_even=2, div_rst=1, busy=0; div_rst=0 one cycle after release.
- Single request: req[1]=1, sel=0, div=5; period_end 2 cycles after entering WAIT_BND -> div_odd=5, one-cycle div_rst, ack[1] pulse, forced=0, div_even stays 2.
- Invalid requests:
  - sel=0, div=4 (even) -> nack, outputs unchanged, no div_rst.
  - sel=1, div=0 -> nack, outputs unchanged, no div_rst.
  - sel=0, div=1 -> nack, outputs unchanged, no div_rst.
- Round-robin: req=4'b1111 held, each requester dropping req on its ack, all valid → grant order 0,1,2,3; then req[0] and req[3] re-raised together with pointer at 0 → requester 0 is served first.
- Timeout: TIMEOUT=16, valid change, no period_end -> apply after 16 WAIT_BND cycles with forced=1 alongside ack. No-op request (div equal to current) -> ack 2 cycles after grant, no div_rst.
- Reset mid-wait: rst asserted in WAIT_BND -> no ack/nack, outputs back to DEF_ODD/DEF_EVEN, busy=0, and a new request afterwards is served normally.
